// File: rtl/pipeline_pkg.sv
// Shared types and widths for the RV32I pipeline: ALU op encoding and the EX-stage control bundle.
package pipeline_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_AW     = 5;
    localparam int CTRL_W     = 3;

    typedef enum logic [CTRL_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              alu_src;
        logic [CTRL_W-1:0] alu_control;
    } ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// 3:1 priority forwarding select for one ALU operand: MEM result, then WB result, then register-file data.
module fwd_mux #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic [AW-1:0] rs,
    input  logic [DW-1:0] reg_data,
    input  logic [AW-1:0] rd_m,
    input  logic          reg_write_m,
    input  logic [DW-1:0] result_m,
    input  logic [AW-1:0] rd_w,
    input  logic          reg_write_w,
    input  logic [DW-1:0] result_w,
    output logic [DW-1:0] fwd_data
);

    // x0 is hardwired zero, so a write to it must never be forwarded.
    always_comb begin
        fwd_data = reg_data;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            fwd_data = result_m;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            fwd_data = result_w;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with M/W operand forwarding and load-use hazard detection.
// Optional macro ID_EX_PERF_EN adds saturating BubbleCnt/FlushCnt performance counters.
module id_ex_stage #(
    parameter int DATA_WIDTH = pipeline_pkg::DATA_WIDTH,
    parameter int REG_AW     = pipeline_pkg::REG_AW,
    parameter int CTRL_W     = pipeline_pkg::CTRL_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ValidD,
    input  logic [CTRL_W-1:0]     ALUControlD,
    input  logic [DATA_WIDTH-1:0] RD1D,
    input  logic [DATA_WIDTH-1:0] RD2D,
    input  logic [DATA_WIDTH-1:0] ImmExtD,
    input  logic [REG_AW-1:0]     Rs1D,
    input  logic [REG_AW-1:0]     Rs2D,
    input  logic [REG_AW-1:0]     RdD,
    input  logic                  RegWriteD,
    input  logic                  MemReadD,
    input  logic                  MemWriteD,
    input  logic                  ALUSrcD,
    input  logic                  StallE,
    input  logic                  FlushE,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [REG_AW-1:0]     RdM,
    input  logic                  RegWriteM,
    input  logic [DATA_WIDTH-1:0] ResultW,
    input  logic [REG_AW-1:0]     RdW,
    input  logic                  RegWriteW,
    output logic                  ValidE,
    output logic                  RegWriteE,
    output logic                  MemReadE,
    output logic                  MemWriteE,
    output logic [CTRL_W-1:0]     ALUControlE,
    output logic [REG_AW-1:0]     RdE,
    output logic [DATA_WIDTH-1:0] SrcAE,
    output logic [DATA_WIDTH-1:0] SrcBE,
    output logic [DATA_WIDTH-1:0] WriteDataE,
    output logic                  LoadUseStall
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]           BubbleCnt,
    output logic [31:0]           FlushCnt
`endif
);

    import pipeline_pkg::*;

    logic                  valid_q, valid_d;
    ex_ctrl_t              ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [REG_AW-1:0]     rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic                  load_use;
    logic [DATA_WIDTH-1:0] fwd_a, fwd_b;

    always_comb begin
        load_use = ValidD && valid_q && ctrl_q.mem_read && (rd_q != '0) &&
                   ((rd_q == Rs1D) || (rd_q == Rs2D));
    end

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        // Flush beats stall; a load-use bubble only applies when E is free to advance.
        if (FlushE || (!StallE && load_use)) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
        end else if (!StallE) begin
            valid_d            = ValidD;
            ctrl_d.reg_write   = RegWriteD && ValidD;
            ctrl_d.mem_read    = MemReadD && ValidD;
            ctrl_d.mem_write   = MemWriteD && ValidD;
            ctrl_d.alu_src     = ALUSrcD;
            ctrl_d.alu_control = ALUControlD;
            rd1_d              = RD1D;
            rd2_d              = RD2D;
            imm_d              = ImmExtD;
            rs1_d              = Rs1D;
            rs2_d              = Rs2D;
            rd_d               = RdD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
        end
    end

    fwd_mux #(.DW(DATA_WIDTH), .AW(REG_AW)) u_fwd_a (
        .rs(rs1_q), .reg_data(rd1_q),
        .rd_m(RdM), .reg_write_m(RegWriteM), .result_m(ALUResultM),
        .rd_w(RdW), .reg_write_w(RegWriteW), .result_w(ResultW),
        .fwd_data(fwd_a)
    );

    fwd_mux #(.DW(DATA_WIDTH), .AW(REG_AW)) u_fwd_b (
        .rs(rs2_q), .reg_data(rd2_q),
        .rd_m(RdM), .reg_write_m(RegWriteM), .result_m(ALUResultM),
        .rd_w(RdW), .reg_write_w(RegWriteW), .result_w(ResultW),
        .fwd_data(fwd_b)
    );

    always_comb begin
        ValidE       = valid_q;
        RegWriteE    = ctrl_q.reg_write;
        MemReadE     = ctrl_q.mem_read;
        MemWriteE    = ctrl_q.mem_write;
        ALUControlE  = ctrl_q.alu_control;
        RdE          = rd_q;
        SrcAE        = fwd_a;
        SrcBE        = ctrl_q.alu_src ? imm_q : fwd_b;
        WriteDataE   = fwd_b;
        LoadUseStall = load_use;
    end

`ifdef ID_EX_PERF_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (!StallE) begin
            if (!FlushE && load_use && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
                bubble_cnt_d = bubble_cnt_q + 32'd1;
            end
            if (FlushE && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_d = flush_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    always_comb begin
        BubbleCnt = bubble_cnt_q;
        FlushCnt  = flush_cnt_q;
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected E-stage snapshots are queued at stimulus time and popped at sample time.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        ValidD;
    logic [2:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, ImmExtD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        RegWriteD, MemReadD, MemWriteD, ALUSrcD;
    logic        StallE, FlushE;
    logic [31:0] ALUResultM, ResultW;
    logic [4:0]  RdM, RdW;
    logic        RegWriteM, RegWriteW;
    logic        ValidE, RegWriteE, MemReadE, MemWriteE;
    logic [2:0]  ALUControlE;
    logic [4:0]  RdE;
    logic [31:0] SrcAE, SrcBE, WriteDataE;
    logic        LoadUseStall;
`ifdef ID_EX_PERF_EN
    logic [31:0] BubbleCnt, FlushCnt;
`endif

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [2:0]  alu;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] wd;
    } snap_t;

    snap_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .ValidD(ValidD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .MemReadD(MemReadD), .MemWriteD(MemWriteD), .ALUSrcD(ALUSrcD),
        .StallE(StallE), .FlushE(FlushE),
        .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
        .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MemWriteE(MemWriteE),
        .ALUControlE(ALUControlE), .RdE(RdE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .WriteDataE(WriteDataE),
        .LoadUseStall(LoadUseStall)
`ifdef ID_EX_PERF_EN
        , .BubbleCnt(BubbleCnt), .FlushCnt(FlushCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic snap_t observed();
        snap_t s;
        s = {ValidE, RegWriteE, MemReadE, MemWriteE, ALUControlE, RdE, SrcAE, SrcBE, WriteDataE};
        return s;
    endfunction

    function automatic snap_t mk(input logic v, rw, mr, mw, input logic [2:0] alu,
                                 input logic [4:0] rd, input logic [31:0] a, b, wd);
        snap_t s;
        s = {v, rw, mr, mw, alu, rd, a, b, wd};
        return s;
    endfunction

    // Independent forwarding reference: M beats W, x0 never forwarded.
    function automatic logic [31:0] fwd_ref(input logic [4:0] rs, input logic [31:0] regv);
        if (RegWriteM && RdM != 5'd0 && RdM == rs) return ALUResultM;
        if (RegWriteW && RdW != 5'd0 && RdW == rs) return ResultW;
        return regv;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic v, input logic [2:0] alu, input logic [31:0] r1, r2, imm,
                         input logic [4:0] s1, s2, d, input logic rw, mr, mw, as);
        ValidD = v; ALUControlD = alu; RD1D = r1; RD2D = r2; ImmExtD = imm;
        Rs1D = s1; Rs2D = s2; RdD = d;
        RegWriteD = rw; MemReadD = mr; MemWriteD = mw; ALUSrcD = as;
    endtask

    task automatic clr_fwd();
        RegWriteM = 1'b0; RdM = 5'd0; ALUResultM = 32'd0;
        RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'd0;
    endtask

    task automatic test_reset();
        snap_t e, o;
        rst = 1'b1; StallE = 1'b0; FlushE = 1'b0;
        clr_fwd();
        RegWriteM = 1'b1; ALUResultM = 32'hDEAD;
        set_d(1'b1, 3'b001, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        exp_q.push_back('0);
        step();
        o = observed(); e = exp_q.pop_front(); checks++;
        if (o !== e) begin failures++; $display("FAIL reset_state got=%h exp=%h", o, e); end
        checks++;
        if (LoadUseStall !== 1'b0) begin failures++; $display("FAIL reset_lus got=%b exp=0", LoadUseStall); end
        rst = 1'b0;
        clr_fwd();
    endtask

    task automatic test_plain_load();
        snap_t e, o;
        set_d(1'b1, 3'b000, 32'd5, 32'd7, 32'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(mk(1, 1, 0, 0, 3'b000, 5'd3, 32'd5, 32'd7, 32'd7));
        step();
        o = observed(); e = exp_q.pop_front(); checks++;
        if (o !== e) begin failures++; $display("FAIL plain_load got=%h exp=%h", o, e); end
        set_d(1'b1, 3'b011, 32'd5, 32'd9, 32'h100, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        exp_q.push_back(mk(1, 1, 0, 1, 3'b011, 5'd4, 32'd5, 32'h100, 32'd9));
        step();
        o = observed(); e = exp_q.pop_front(); checks++;
        if (o !== e) begin failures++; $display("FAIL imm_select got=%h exp=%h", o, e); end
    endtask

    task automatic test_fwd_priority();
        logic [31:0] e;
        set_d(1'b1, 3'b000, 32'h11, 32'h22, 32'h0, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        set_d(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        RegWriteM = 1'b1; RdM = 5'd3; ALUResultM = 32'hAA;
        RegWriteW = 1'b1; RdW = 5'd3; ResultW = 32'hBB;
        #1; checks++;
        if (SrcAE !== 32'hAA) begin failures++; $display("FAIL fwd_m_over_w got=%h exp=000000aa", SrcAE); end
        RdM = 5'd0;
        #1; checks++;
        if (SrcAE !== 32'hBB) begin failures++; $display("FAIL fwd_w got=%h exp=000000bb", SrcAE); end
        RegWriteW = 1'b0;
        #1; checks++;
        if (SrcAE !== 32'h11) begin failures++; $display("FAIL fwd_none got=%h exp=00000011", SrcAE); end
        RdM = 5'd4;
        e = 32'hAA;
        #1; checks++;
        if ({SrcBE, WriteDataE} !== {e, e}) begin
            failures++; $display("FAIL fwd_rs2 got=%h/%h exp=%h", SrcBE, WriteDataE, e);
        end
        RegWriteM = 1'b0;
        #1; checks++;
        if (WriteDataE !== 32'h22) begin failures++; $display("FAIL fwd_rs2_none got=%h exp=00000022", WriteDataE); end
        clr_fwd();
    endtask

    task automatic test_x0_guard();
        set_d(1'b1, 3'b000, 32'h33, 32'h44, 32'h0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        RegWriteM = 1'b1; RdM = 5'd0; ALUResultM = 32'h55;
        RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'h66;
        #1; checks++;
        if ({SrcAE, SrcBE} !== {32'h33, 32'h44}) begin
            failures++; $display("FAIL x0_guard got=%h/%h exp=00000033/00000044", SrcAE, SrcBE);
        end
        clr_fwd();
    endtask

    task automatic test_load_use();
        snap_t e, o;
        set_d(1'b1, 3'b000, 32'h40, 32'h0, 32'h4, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        set_d(1'b1, 3'b001, 32'h60, 32'h70, 32'h0, 5'd6, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        #1; checks++;
        if (LoadUseStall !== 1'b1) begin failures++; $display("FAIL load_use_detect got=%b exp=1", LoadUseStall); end
        exp_q.push_back(mk(0, 0, 0, 0, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0));
        step();
        o = observed(); e = exp_q.pop_front(); checks++;
        if ({o.valid, o.rw, o.mr, o.mw} !== {e.valid, e.rw, e.mr, e.mw}) begin
            failures++; $display("FAIL load_use_bubble got=%b exp=%b", {o.valid, o.rw, o.mr, o.mw}, {e.valid, e.rw, e.mr, e.mw});
        end
        checks++;
        if (LoadUseStall !== 1'b0) begin failures++; $display("FAIL load_use_release got=%b exp=0", LoadUseStall); end
        exp_q.push_back(mk(1, 1, 0, 0, 3'b001, 5'd7, 32'h60, 32'h70, 32'h70));
        step();
        o = observed(); e = exp_q.pop_front(); checks++;
        if (o !== e) begin failures++; $display("FAIL load_use_replay got=%h exp=%h", o, e); end
        // A load into x0 can never create a hazard.
        set_d(1'b1, 3'b000, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        set_d(1'b1, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        #1; checks++;
        if (LoadUseStall !== 1'b0) begin failures++; $display("FAIL load_x0_no_stall got=%b exp=0", LoadUseStall); end
        // Load in E but bubble in D: no stall request.
        set_d(1'b1, 3'b000, 32'h0, 32'h0, 32'h0, 5'd1, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        set_d(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd9, 5'd9, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        #1; checks++;
        if (LoadUseStall !== 1'b0) begin failures++; $display("FAIL load_use_invalid_d got=%b exp=0", LoadUseStall); end
        exp_q.push_back(mk(0, 0, 0, 0, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0));
        step();
        o = observed(); e = exp_q.pop_front(); checks++;
        if ({o.valid, o.rw, o.mr, o.mw} !== {e.valid, e.rw, e.mr, e.mw}) begin
            failures++; $display("FAIL validd_gate got=%b exp=%b", {o.valid, o.rw, o.mr, o.mw}, {e.valid, e.rw, e.mr, e.mw});
        end
    endtask

    task automatic test_flush_stall();
        snap_t e, o;
        set_d(1'b1, 3'b010, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        FlushE = 1'b1; StallE = 1'b1;
        set_d(1'b1, 3'b011, 32'h3, 32'h4, 32'h0, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(mk(0, 0, 0, 0, 3'b000, 5'd0, 32'd0, 32'd0, 32'd0));
        step();
        o = observed(); e = exp_q.pop_front(); checks++;
        if ({o.valid, o.rw, o.mr, o.mw} !== {e.valid, e.rw, e.mr, e.mw}) begin
            failures++; $display("FAIL flush_over_stall got=%b exp=%b", {o.valid, o.rw, o.mr, o.mw}, {e.valid, e.rw, e.mr, e.mw});
        end
        FlushE = 1'b0; StallE = 1'b0;
        set_d(1'b1, 3'b101, 32'hC1, 32'hC2, 32'h0, 5'd10, 5'd11, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_d(1'b1, 3'(i), 32'(i), 32'(i + 1), 32'(i + 2), 5'(i), 5'(i), 5'(20 + i), 1'b0, 1'b1, 1'b1, 1'b1);
            exp_q.push_back(mk(1, 1, 0, 0, 3'b101, 5'd12, 32'hC1, 32'hC2, 32'hC2));
            step();
            o = observed(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL stall_hold_%0d got=%h exp=%h", i, o, e); end
        end
        // Asynchronous reset in the middle of a stall empties the stage without a clock edge.
        #2 rst = 1'b1;
        #1; checks++;
        if ({ValidE, RegWriteE, RdE} !== 7'd0) begin
            failures++; $display("FAIL reset_mid_stall got=%b exp=0", {ValidE, RegWriteE, RdE});
        end
        step();
        rst = 1'b0; StallE = 1'b0;
    endtask

    task automatic test_back_to_back();
        snap_t e, o;
        logic [31:0] r1, r2, imm, a, wd;
        logic [4:0]  s1, s2, d;
        logic [2:0]  alu;
        logic        rw, mw, as;
        for (int i = 0; i < 20; i++) begin
            r1 = $urandom; r2 = $urandom; imm = $urandom;
            s1 = 5'($urandom_range(0, 3)); s2 = 5'($urandom_range(0, 3)); d = 5'($urandom_range(0, 31));
            alu = 3'($urandom_range(0, 7));
            rw = 1'($urandom); mw = 1'($urandom); as = 1'($urandom);
            set_d(1'b1, alu, r1, r2, imm, s1, s2, d, rw, 1'b0, mw, as);
            RegWriteM = 1'($urandom); RdM = 5'($urandom_range(0, 3)); ALUResultM = $urandom;
            RegWriteW = 1'($urandom); RdW = 5'($urandom_range(0, 3)); ResultW = $urandom;
            a  = fwd_ref(s1, r1);
            wd = fwd_ref(s2, r2);
            exp_q.push_back(mk(1, rw, 0, mw, alu, d, a, as ? imm : wd, wd));
            step();
            o = observed(); e = exp_q.pop_front(); checks++;
            if (o !== e) begin failures++; $display("FAIL b2b_%0d got=%h exp=%h", i, o, e); end
        end
        clr_fwd();
    endtask

    initial begin
        test_reset();
        test_plain_load();
        test_fwd_priority();
        test_x0_guard();
        test_load_use();
        test_flush_stall();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
